// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and defaults for the chunked wide-adder sequencer.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_TOTAL_BITS = 16;
  localparam int DEF_CHUNK_BITS = 4;

  // Width of the chunk counter; never narrower than one bit.
  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Narrow unsigned adder shared by the sequencer, one chunk per cycle.
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide unsigned adder built by walking one adder_nbit across the operands,
// least-significant chunk first, with a registered carry between chunks.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int TOTAL_BITS = DEF_TOTAL_BITS,
  parameter int CHUNK_BITS = DEF_CHUNK_BITS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] b,
  input  logic                  carry_in,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  result_valid,
  output logic [TOTAL_BITS-1:0] sum,
  output logic                  overflow
);

  localparam int NUM_CHUNKS = TOTAL_BITS / CHUNK_BITS;
  localparam int IDX_W      = idx_width(NUM_CHUNKS);

  if (TOTAL_BITS % CHUNK_BITS != 0) begin : g_bad_width
    $fatal(1, "adder_seq_ctrl: TOTAL_BITS must be a multiple of CHUNK_BITS");
  end

  state_t                r_state;
  logic [IDX_W-1:0]      r_chunk_idx;
  logic                  r_carry;
  logic [TOTAL_BITS-1:0] r_a;
  logic [TOTAL_BITS-1:0] r_b;
  logic [TOTAL_BITS-1:0] r_sum;
  logic                  r_overflow;

  int                    w_base;
  logic [CHUNK_BITS-1:0] w_chunk_sum;
  logic                  w_chunk_ovf;

  assign w_base = int'(r_chunk_idx) * CHUNK_BITS;

  adder_nbit #(
    .BIT_WIDTH (CHUNK_BITS)
  ) u_adder (
    .a        (r_a[w_base +: CHUNK_BITS]),
    .b        (r_b[w_base +: CHUNK_BITS]),
    .carry_in (r_carry),
    .sum      (w_chunk_sum),
    .overflow (w_chunk_ovf)
  );

  // Sequencer: latch operands on start, add one chunk per cycle, hold result until accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_chunk_idx <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a         <= a;
            r_b         <= b;
            r_carry     <= carry_in;
            r_chunk_idx <= '0;
            r_state     <= ADD;
          end
        end
        ADD: begin
          r_sum[w_base +: CHUNK_BITS] <= w_chunk_sum;
          r_carry                     <= w_chunk_ovf;
          if (r_chunk_idx == IDX_W'(NUM_CHUNKS - 1)) begin
            r_overflow  <= w_chunk_ovf;
            r_chunk_idx <= '0;
            r_state     <= DONE;
          end else begin
            r_chunk_idx <= r_chunk_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_chunk_idx <= '0;
        end
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign sum          = r_sum;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a queue-based scoreboard and an independent result monitor.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        result_ready;
  logic        busy;
  logic        result_valid;
  logic [15:0] sum;
  logic        overflow;

  int          checks       = 0;
  int          failures     = 0;
  int          results_seen = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;

  always #5 clk = ~clk;

  adder_seq_ctrl #(
    .TOTAL_BITS (16),
    .CHUNK_BITS (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .a            (a),
    .b            (b),
    .carry_in     (carry_in),
    .result_ready (result_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .sum          (sum),
    .overflow     (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (n_rst && result_valid && result_ready) begin
      results_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got sum=%h ovf=%b expected no result", sum, overflow);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({overflow, sum} !== mon_exp) begin
          failures++;
          $display("FAIL sb_result: got sum=%h ovf=%b expected sum=%h ovf=%b",
                   sum, overflow, mon_exp[15:0], mon_exp[16]);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin);
    start    = 1'b1;
    a        = ia;
    b        = ib;
    carry_in = icin;
    @(posedge clk);
    #1;
    start    = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    carry_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic [15:0] esum, input logic eovf);
    int n;
    exp_q.push_back({eovf, esum});
    issue(ia, ib, icin);
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_valid(n);
    chk({name, "_latency"}, n, 32'd4);
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {30'd0, busy, result_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_rst        = 1'b0;
    start        = 1'b0;
    a            = 16'h0000;
    b            = 16'h0000;
    carry_in     = 1'b0;
    result_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {13'd0, busy, result_valid, overflow, sum}, 32'd0);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_outputs", {13'd0, busy, result_valid, overflow, sum}, 32'd0);

    run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("ripple1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("ripple2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Backpressure: result must be held while ready is low.
    result_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h0100});
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_valid(n);
    chk("bp_latency", n, 32'd4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {14'd0, result_valid, overflow, sum}, {14'd0, 1'b1, 1'b0, 16'h0100});
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {30'd0, busy, result_valid}, 32'd0);

    // A start during ADD must be dropped.
    exp_q.push_back({1'b0, 16'h3333});
    issue(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(n);
    chk("ign_reached_done", {31'd0, result_valid}, 32'd1);
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_not_queued", {31'd0, busy}, 32'd0);

    run_op("b2b1", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0);
    run_op("b2b2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Reset during the second ADD cycle discards the operation.
    issue(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_outputs", {13'd0, busy, result_valid, overflow, sum}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    run_op("post_rst", 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("results_count", results_seen, 32'd8);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
